// File: rtl/keypad_scanner.sv
// Purpose: scans a 4x3 active-low keypad, debounces full-scan snapshots and drives
//          one-hot digit / start / clear levels (or single-cycle pulses).
// Latency: one scan period is 3*SCAN_DIV cycles; a stable press or release commits
//          DEBOUNCE_SCANS identical scans later, plus two cycles for evaluation and commit.
// Backpressure: none. The keypad is sampled continuously and the outputs are plain levels.
//
// Ports:
//   clock   - system clock, rising edge
//   resetn  - asynchronous active-low reset
//   rows    - keypad row sense lines, active-low, asynchronous to clock
//   cols    - keypad column drives, active-low, exactly one low at a time
//   keypad  - one-hot committed digit (bit d = digit d)
//   startn  - low while '#' is committed
//   clearn  - low while '*' is committed
//
// Build option: define KEYPAD_PULSE_EN to turn each new non-NONE commit into a
// single-cycle output pulse instead of a held level.

module keypad_scanner #(
  parameter int SCAN_DIV       = 4,
  parameter int DEBOUNCE_SCANS = 3
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic [3:0] rows,
  output logic [2:0] cols,
  output logic [9:0] keypad,
  output logic       startn,
  output logic       clearn
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

  localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] MATCH_MAX = MW'(DEBOUNCE_SCANS);

  // Key codes: 0..9 digits, 10 '*', 11 '#', 15 no key.
  localparam logic [3:0] CODE_STAR = 4'd10;
  localparam logic [3:0] CODE_HASH = 4'd11;
  localparam logic [3:0] CODE_NONE = 4'd15;

  // Snapshot bit index is {col, row}; map it to the printed key.
  function automatic logic [3:0] key_at(input logic [3:0] idx);
    logic [1:0] r;
    logic [1:0] c;
    r = idx[1:0];
    c = idx[3:2];
    if (r != 2'd3) begin
      key_at = ({2'b00, r} * 4'd3) + {2'b00, c} + 4'd1;
    end else begin
      case (c)
        2'd0:    key_at = CODE_STAR;
        2'd1:    key_at = 4'd0;
        default: key_at = CODE_HASH;
      endcase
    end
  endfunction

  logic [3:0]    sync1_q,  sync2_q;
  logic [SW-1:0] slot_q,   slot_d;
  logic [1:0]    col_q,    col_d;
  logic [2:0]    cols_q,   cols_d;
  logic [11:0]   snap_q,   snap_d;
  logic          eval_q,   eval_d;
  logic          cmt_q;
  logic [3:0]    prev_q,   prev_d;
  logic [MW-1:0] match_q,  match_d;
  logic [3:0]    commit_q, commit_d;
  logic [9:0]    keypad_q, keypad_d;
  logic          startn_q, startn_d;
  logic          clearn_q, clearn_d;

  logic          last_slot;
  logic [3:0]    hit_cnt;
  logic [3:0]    hit_idx;
  logic [3:0]    snap_code;
  logic          commit_en;

  // Scan timing: each column is driven for SCAN_DIV cycles; the rows are sampled
  // on the last cycle so the synchronizer has settled after the column change.
  always_comb begin
    last_slot = (slot_q == SLOT_LAST);
    slot_d    = last_slot ? '0 : slot_q + 1'b1;
    col_d     = col_q;
    if (last_slot) begin
      col_d = (col_q == 2'd2) ? 2'd0 : col_q + 2'd1;
    end
    cols_d = ~(3'b001 << col_d);
    eval_d = last_slot && (col_q == 2'd2);

    snap_d = snap_q;
    if (last_slot) begin
      case (col_q)
        2'd0:    snap_d[3:0]  = ~sync2_q;
        2'd1:    snap_d[7:4]  = ~sync2_q;
        default: snap_d[11:8] = ~sync2_q;
      endcase
    end
  end

  // Classify a complete snapshot: exactly one pressed contact is a key,
  // anything else (nothing or a chord) is treated as no key.
  always_comb begin
    hit_cnt = '0;
    hit_idx = '0;
    for (int i = 0; i < 12; i++) begin
      if (snap_q[i]) begin
        hit_cnt = hit_cnt + 4'd1;
        hit_idx = 4'(i);
      end
    end
    snap_code = (hit_cnt == 4'd1) ? key_at(hit_idx) : CODE_NONE;
  end

  // Debounce: count consecutive identical snapshot codes, saturating.
  always_comb begin
    prev_d  = prev_q;
    match_d = match_q;
    if (eval_q) begin
      prev_d = snap_code;
      if (snap_code == prev_q) begin
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + 1'b1;
      end else begin
        match_d = MW'(1);
      end
    end
  end

  // Commit happens the cycle after evaluation, using the freshly updated counter.
  always_comb begin
    commit_en = cmt_q && (match_q == MATCH_MAX) && (prev_q != commit_q);
    commit_d  = commit_en ? prev_q : commit_q;

`ifdef KEYPAD_PULSE_EN
    keypad_d = '0;
    startn_d = 1'b1;
    clearn_d = 1'b1;
`else
    keypad_d = keypad_q;
    startn_d = startn_q;
    clearn_d = clearn_q;
`endif
    if (commit_en) begin
      keypad_d = (prev_q < 4'd10) ? (10'd1 << prev_q) : '0;
      startn_d = (prev_q != CODE_HASH);
      clearn_d = (prev_q != CODE_STAR);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q  <= 4'b1111;
      sync2_q  <= 4'b1111;
      slot_q   <= '0;
      col_q    <= 2'd0;
      cols_q   <= 3'b110;
      snap_q   <= '0;
      eval_q   <= 1'b0;
      cmt_q    <= 1'b0;
      prev_q   <= CODE_NONE;
      match_q  <= '0;
      commit_q <= CODE_NONE;
      keypad_q <= '0;
      startn_q <= 1'b1;
      clearn_q <= 1'b1;
    end else begin
      sync1_q  <= rows;
      sync2_q  <= sync1_q;
      slot_q   <= slot_d;
      col_q    <= col_d;
      cols_q   <= cols_d;
      snap_q   <= snap_d;
      eval_q   <= eval_d;
      cmt_q    <= eval_q;
      prev_q   <= prev_d;
      match_q  <= match_d;
      commit_q <= commit_d;
      keypad_q <= keypad_d;
      startn_q <= startn_d;
      clearn_q <= clearn_d;
    end
  end

  assign cols   = cols_q;
  assign keypad = keypad_q;
  assign startn = startn_q;
  assign clearn = clearn_q;

endmodule
